// File: rtl/weight_mem_loader_pkg.sv
// Shared constants and state encoding for the weight memory loader.
package weight_mem_loader_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned HDR_LAYER_HI  = 31;
  localparam int unsigned HDR_LAYER_LO  = 24;
  localparam int unsigned HDR_NEURON_HI = 23;
  localparam int unsigned HDR_NEURON_LO = 16;
  localparam int unsigned HDR_CNT_HI    = 15;
  localparam int unsigned HDR_CNT_LO    = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/weight_unpack_2to1.sv
// Splits a 32-bit stream word into two 16-bit weights; the upper half is held for the HI phase.
module weight_unpack_2to1
  import weight_mem_loader_pkg::*;
#(
  parameter int unsigned dataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_ready,
  input  logic                 hi_phase,
  input  logic [WORD_W-1:0]    in_data,
  output logic                 out_valid,
  output logic [dataWidth-1:0] out_data
);

  logic [dataWidth-1:0] hi_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q <= '0;
    end else if (in_valid && in_ready && !hi_phase) begin
      hi_q <= in_data[2*dataWidth-1:dataWidth];
    end
  end

  always_comb begin
    out_valid = hi_phase || (in_valid && in_ready);
    out_data  = hi_phase ? hi_q : in_data[dataWidth-1:0];
  end

endmodule

// File: rtl/weight_mem_loader.sv
// Header-decoding loader that turns a packed word stream into per-neuron weight memory writes.
module weight_mem_loader
  import weight_mem_loader_pkg::*;
#(
  parameter int unsigned addressWidth = 10,
  parameter int unsigned dataWidth    = 16,
  parameter int unsigned maxLayers    = 4,
  parameter int unsigned maxNeurons   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [WORD_W-1:0]       s_data,
  output logic                    wen,
  output logic [addressWidth:0]   waddr,
  output logic [dataWidth-1:0]    win,
  output logic [7:0]              w_layer,
  output logic [7:0]              w_neuron,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned CW    = addressWidth + 1;
  localparam int unsigned MAX_N = 1 << addressWidth;
  localparam logic [addressWidth:0] ONE = CW'(1);

  state_t                state, state_n;
  logic [addressWidth:0] addr, addr_n;
  logic [addressWidth:0] rem, rem_n;
  logic                  s_ready_n, wen_n, busy_n, done_n, err_n;
  logic [addressWidth:0] waddr_n;
  logic [dataWidth-1:0]  win_n;
  logic [7:0]            layer_n, neuron_n;

  logic                  accept;
  logic [7:0]            hdr_layer, hdr_neuron;
  logic [15:0]           hdr_cnt;
  logic                  hdr_bad;
  logic                  lane_valid;
  logic [dataWidth-1:0]  lane_data;

  assign accept     = s_valid && s_ready;
  assign hdr_layer  = s_data[HDR_LAYER_HI:HDR_LAYER_LO];
  assign hdr_neuron = s_data[HDR_NEURON_HI:HDR_NEURON_LO];
  assign hdr_cnt    = s_data[HDR_CNT_HI:HDR_CNT_LO];
  assign hdr_bad    = (32'(hdr_layer) >= maxLayers) || (32'(hdr_neuron) >= maxNeurons) ||
                      (hdr_cnt == '0) || (32'(hdr_cnt) > MAX_N);

  weight_unpack_2to1 #(.dataWidth(dataWidth)) u_unpack (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_valid),
    .in_ready  (state == ST_LO),
    .hi_phase  (state == ST_HI),
    .in_data   (s_data),
    .out_valid (lane_valid),
    .out_data  (lane_data)
  );

  always_comb begin
    state_n  = state;
    addr_n   = addr;
    rem_n    = rem;
    wen_n    = 1'b0;
    waddr_n  = waddr;
    win_n    = win;
    layer_n  = w_layer;
    neuron_n = w_neuron;
    err_n    = err;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (hdr_bad) begin
            err_n = 1'b1;
          end else begin
            layer_n  = hdr_layer;
            neuron_n = hdr_neuron;
            rem_n    = CW'(hdr_cnt);
            addr_n   = '0;
            state_n  = ST_LO;
          end
        end
      end
      ST_LO, ST_HI: begin
        // LO writes only on an accepted word; HI always writes the held upper half.
        if (lane_valid) begin
          wen_n   = 1'b1;
          win_n   = lane_data;
          waddr_n = addr;
          addr_n  = addr + 1'b1;
          rem_n   = rem - 1'b1;
          if (rem == ONE)          state_n = ST_DONE;
          else if (state == ST_LO) state_n = ST_HI;
          else                     state_n = ST_LO;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    s_ready_n = (state_n == ST_IDLE) || (state_n == ST_LO);
    // busy stays up through the done pulse and drops one cycle later.
    busy_n    = (state_n != ST_IDLE) || (state == ST_DONE);
    done_n    = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      addr     <= '0;
      rem      <= '0;
      s_ready  <= 1'b1;
      wen      <= 1'b0;
      waddr    <= '0;
      win      <= '0;
      w_layer  <= '0;
      w_neuron <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      addr     <= addr_n;
      rem      <= rem_n;
      s_ready  <= s_ready_n;
      wen      <= wen_n;
      waddr    <= waddr_n;
      win      <= win_n;
      w_layer  <= layer_n;
      w_neuron <= neuron_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

endmodule
